// File: rtl/gb_loader_pkg.sv
// gb_loader_pkg: memory-writer FSM encoding and cartridge header word offsets.
package gb_loader_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN} wr_state_e;
   localparam logic [24:0] HDR_CART_WORD = 25'h00000A3;
   localparam logic [24:0] HDR_SIZE_WORD = 25'h00000A4;
endpackage

// File: rtl/ioctl_word_fifo.sv
// ioctl_word_fifo: small synchronous FIFO with occupancy count for the download word stream.
module ioctl_word_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign dout    = mem_q[rd_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/ioctl_rom_writer.sv
// ioctl_rom_writer: queues ROM download words and writes them to memory over a req/ack handshake,
// capturing the cartridge header and reporting the committed download size.
module ioctl_rom_writer
   import gb_loader_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  ROM_INDEX  = 8'h00
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic        ioctl_clkref,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic        mem_ack,
   output logic        rom_loaded,
   output logic [24:0] rom_words,
   output logic [7:0]  cart_type,
   output logic [7:0]  rom_size,
   output logic [7:0]  ram_size,
   output logic        overflow
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   wr_state_e      state_q;
   logic           dl_q, armed_q, any_q;
   logic [24:0]    max_q;
   logic [39:0]    head;
   logic [CW-1:0]  cnt, cnt_d;
   logic           full, empty, qual, push, pop, rise, fall;

   assign qual  = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
   assign push  = qual & ~full;
   assign pop   = (state_q == ST_REQ) & mem_ack;
   assign rise  = ioctl_download & ~dl_q;
   assign fall  = ~ioctl_download & dl_q;
   assign cnt_d = cnt + CW'(push) - CW'(pop);

   // Address bit 24 never reaches memory, so only 24 address bits are queued.
   ioctl_word_fifo #(.WIDTH(40), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_sys),
      .rst_n (reset_n),
      .push  (push),
      .pop   (pop),
      .din   ({ioctl_addr[23:0], ioctl_dout}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (cnt)
   );

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         dl_q         <= 1'b0;
         ioctl_clkref <= 1'b0;
         overflow     <= 1'b0;
         cart_type    <= '0;
         rom_size     <= '0;
         ram_size     <= '0;
         max_q        <= '0;
         any_q        <= 1'b0;
      end else begin
         dl_q         <= ioctl_download;
         ioctl_clkref <= cnt_d <= CW'(FIFO_DEPTH - 2);
         if (rise) begin
            overflow  <= 1'b0;
            cart_type <= '0;
            rom_size  <= '0;
            ram_size  <= '0;
            max_q     <= '0;
            any_q     <= 1'b0;
         end
         if (qual & full) overflow <= 1'b1;
         if (push) begin
            if (rise | ~any_q | (ioctl_addr > max_q)) max_q <= ioctl_addr;
            any_q <= 1'b1;
            if (ioctl_addr == HDR_CART_WORD) cart_type <= ioctl_dout[7:0];
            if (ioctl_addr == HDR_SIZE_WORD) {rom_size, ram_size} <= ioctl_dout;
         end
      end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         rom_loaded <= 1'b0;
         rom_words  <= '0;
         armed_q    <= 1'b0;
      end else begin
         rom_loaded <= 1'b0;
         if (fall) armed_q <= 1'b1;
         else if (rise) armed_q <= 1'b0;
         case (state_q)
            ST_REQ:
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_q <= ioctl_download ? ST_IDLE : ST_DRAIN;
               end
            default:
               if (!empty) begin
                  mem_req  <= 1'b1;
                  mem_addr <= head[39:16];
                  mem_din  <= head[15:0];
                  state_q  <= ST_REQ;
               end else if (armed_q) begin
                  rom_loaded <= 1'b1;
                  rom_words  <= any_q ? max_q + 25'd1 : '0;
                  armed_q    <= 1'b0;
                  state_q    <= ST_IDLE;
               end
         endcase
      end
endmodule

// File: tb/tb_ioctl_rom_writer.sv
// tb_ioctl_rom_writer: scenario tasks against a queue-based model of accepted words and download results.
module tb_ioctl_rom_writer;
   localparam int D = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [15:0] ioctl_dout = '0;
   logic        ioctl_clkref;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_ack = 1'b0;
   logic        rom_loaded;
   logic [24:0] rom_words;
   logic [7:0]  cart_type, rom_size, ram_size;
   logic        overflow;

   ioctl_rom_writer #(.FIFO_DEPTH(D), .ROM_INDEX(8'h00)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_clkref   (ioctl_clkref),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_ack        (mem_ack),
      .rom_loaded     (rom_loaded),
      .rom_words      (rom_words),
      .cart_type      (cart_type),
      .rom_size       (rom_size),
      .ram_size       (ram_size),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int          tests = 0;
   int          fails = 0;
   logic [39:0] exp_q[$];
   int          occ = 0;
   bit          m_any, m_ovf, saw_full_margin;
   logic [24:0] m_max;
   logic [7:0]  m_cart, m_rsz, m_ramsz;

   task automatic dl_start();
      ioctl_download = 1'b1;
      m_any = 0; m_ovf = 0; m_max = '0; m_cart = '0; m_rsz = '0; m_ramsz = '0;
      @(negedge clk_sys);
   endtask

   task automatic dl_end();
      ioctl_download = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [7:0] idx);
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; ioctl_index = idx;
      if (ioctl_download && idx == 8'h00) begin
         if (occ < D) begin
            exp_q.push_back({a[23:0], d});
            occ++;
            if (!m_any || a > m_max) m_max = a;
            m_any = 1;
            if (a == 25'h0A3) m_cart = d[7:0];
            if (a == 25'h0A4) {m_rsz, m_ramsz} = d;
         end else m_ovf = 1;
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
   endtask

   task automatic serve(input int n, input int mind, input int maxd);
      for (int k = 0; k < n; k++) begin
         int t = 0;
         int dly;
         logic [23:0] a;
         logic [15:0] d;
         while (mem_req !== 1'b1 && t < 500) begin @(negedge clk_sys); t++; end
         tests++;
         if (t >= 500) begin
            fails++;
            $display("FAIL serve_timeout word %0d: mem_req=%b required 1", k, mem_req);
            return;
         end
         if (exp_q.size() == 0 || mem_addr !== exp_q[0][39:16] || mem_din !== exp_q[0][15:0]) begin
            fails++;
            $display("FAIL req_data word %0d: addr=%h din=%h required %h", k, mem_addr, mem_din,
                     exp_q.size() ? exp_q[0] : 40'h0);
         end
         a = mem_addr; d = mem_din;
         dly = $urandom_range(maxd, mind);
         repeat (dly) begin
            @(negedge clk_sys);
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== a || mem_din !== d) begin
               fails++;
               $display("FAIL req_hold word %0d: req=%b addr=%h din=%h required 1 %h %h", k, mem_req, mem_addr, mem_din, a, d);
            end
         end
         mem_ack = 1'b1;
         @(posedge clk_sys);
         #1;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         occ--;
         @(negedge clk_sys);
         mem_ack = 1'b0;
         tests++;
         if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL req_drop word %0d: mem_req=%b required 0", k, mem_req);
         end
      end
   endtask

   task automatic gated_writes(input int n, input logic [24:0] base);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         logic [24:0] a;
         logic [15:0] d;
         a = base + 25'(i);
         d = (a == 25'h0A3) ? 16'h0013 : (a == 25'h0A4) ? 16'h0502 : 16'($urandom());
         while (t < 100) begin
            tests++;
            if (ioctl_clkref !== (occ <= D - 2)) begin
               fails++;
               $display("FAIL clkref occ=%0d: clkref=%b required %b", occ, ioctl_clkref, occ <= D - 2);
            end
            if (occ == D - 1) saw_full_margin = 1;
            if (ioctl_clkref === 1'b1) break;
            @(negedge clk_sys);
            t++;
         end
         if (t >= 100) begin
            tests++; fails++;
            $display("FAIL clkref_timeout word %0d: clkref=%b required 1", i, ioctl_clkref);
            return;
         end
         wr(a, d, 8'h00);
      end
   endtask

   task automatic wait_loaded(input string name);
      int t = 0;
      while (rom_loaded !== 1'b1 && t < 200) begin @(negedge clk_sys); t++; end
      tests++;
      if (t >= 200) begin
         fails++;
         $display("FAIL %s loaded_timeout: rom_loaded=%b required 1", name, rom_loaded);
         return;
      end
      if (rom_words !== (m_any ? m_max + 25'd1 : 25'd0) || exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s rom_words: got %h required %h (pending %0d)", name, rom_words, m_any ? m_max + 25'd1 : 25'd0, exp_q.size());
      end
      tests++;
      if ({cart_type, rom_size, ram_size, overflow} !== {m_cart, m_rsz, m_ramsz, m_ovf}) begin
         fails++;
         $display("FAIL %s header: got %h %h %h ovf=%b required %h %h %h ovf=%b", name,
                  cart_type, rom_size, ram_size, overflow, m_cart, m_rsz, m_ramsz, m_ovf);
      end
      @(negedge clk_sys);
      tests++;
      if (rom_loaded !== 1'b0) begin
         fails++;
         $display("FAIL %s loaded_pulse: rom_loaded=%b required 0", name, rom_loaded);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_sys);
      tests++;
      if ({mem_req, mem_addr, mem_din, ioctl_clkref, rom_loaded, rom_words, cart_type, rom_size, ram_size, overflow} !== '0) begin
         fails++;
         $display("FAIL reset_state: req=%b addr=%h din=%h clkref=%b loaded=%b words=%h hdr=%h%h%h ovf=%b required all 0",
                  mem_req, mem_addr, mem_din, ioctl_clkref, rom_loaded, rom_words, cart_type, rom_size, ram_size, overflow);
      end
      reset_n = 1'b1;
      @(negedge clk_sys);
      tests++;
      if (ioctl_clkref !== 1'b1) begin
         fails++;
         $display("FAIL reset_clkref: clkref=%b required 1", ioctl_clkref);
      end
   endtask

   task automatic test_single();
      dl_start();
      wr(25'h000010, 16'hBEEF, 8'h00);
      serve(1, 3, 3);
      repeat (4) begin
         @(negedge clk_sys);
         tests++;
         if (mem_req !== 1'b0) begin fails++; $display("FAIL single_extra_req: mem_req=%b required 0", mem_req); end
      end
      dl_end();
      wait_loaded("single");
   endtask

   task automatic test_ack_ignored();
      dl_start();
      wr(25'h000020, 16'($urandom()), 8'h00);
      mem_ack = 1'b1;
      wr(25'h000021, 16'($urandom()), 8'h00);
      mem_ack = 1'b0;
      serve(2, 0, 2);
      dl_end();
      wait_loaded("ack_ignored");
   endtask

   task automatic test_clkref();
      saw_full_margin = 0;
      dl_start();
      fork
         gated_writes(5, 25'h001000);
         begin repeat (15) @(negedge clk_sys); serve(5, 0, 2); end
      join
      tests++;
      if (saw_full_margin !== 1'b1 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL clkref_margin: reached_occ3=%b overflow=%b required 1 0", saw_full_margin, overflow);
      end
      dl_end();
      wait_loaded("clkref");
   endtask

   task automatic test_overflow();
      dl_start();
      for (int i = 0; i < 5; i++) wr(25'($urandom()), 16'($urandom()), 8'h00);
      tests++;
      if (overflow !== 1'b1 || ioctl_clkref !== 1'b0 || exp_q.size() != 4) begin
         fails++;
         $display("FAIL overflow_flag: overflow=%b clkref=%b queued=%0d required 1 0 4", overflow, ioctl_clkref, exp_q.size());
      end
      repeat (3) @(negedge clk_sys);
      serve(4, 0, 3);
      repeat (4) begin
         @(negedge clk_sys);
         tests++;
         if (mem_req !== 1'b0) begin fails++; $display("FAIL overflow_extra_req: mem_req=%b required 0", mem_req); end
      end
      dl_end();
      wait_loaded("overflow");
   endtask

   task automatic test_header();
      dl_start();
      fork
         gated_writes(512, 25'h0);
         serve(512, 0, 2);
      join
      dl_end();
      wait_loaded("header");
      tests++;
      if ({cart_type, rom_size, ram_size, rom_words} !== {8'h13, 8'h05, 8'h02, 25'h200}) begin
         fails++;
         $display("FAIL header_values: got %h %h %h words=%h required 13 05 02 words=200", cart_type, rom_size, ram_size, rom_words);
      end
   endtask

   task automatic test_index();
      dl_start();
      for (int i = 0; i < 6; i++) wr(25'($urandom_range(255, 0)), 16'($urandom()), 8'($urandom_range(255, 1)));
      repeat (8) begin
         @(negedge clk_sys);
         tests++;
         if (mem_req !== 1'b0) begin fails++; $display("FAIL index_req: mem_req=%b required 0", mem_req); end
      end
      dl_end();
      wait_loaded("index");
   endtask

   task automatic test_reset_req();
      int t = 0;
      dl_start();
      wr(25'h000300, 16'($urandom()), 8'h00);
      wr(25'h000301, 16'($urandom()), 8'h00);
      while (mem_req !== 1'b1 && t < 20) begin @(negedge clk_sys); t++; end
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      #1;
      tests++;
      if (mem_req !== 1'b0 || mem_addr !== 24'h0 || ioctl_clkref !== 1'b0 || t >= 20) begin
         fails++;
         $display("FAIL reset_in_req: req=%b addr=%h clkref=%b waited=%0d required 0 0 0 <20", mem_req, mem_addr, ioctl_clkref, t);
      end
      exp_q.delete(); occ = 0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      tests++;
      if (ioctl_clkref !== 1'b1) begin fails++; $display("FAIL reset_release_clkref: clkref=%b required 1", ioctl_clkref); end
      repeat (5) begin
         @(negedge clk_sys);
         tests++;
         if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_fifo_empty: mem_req=%b required 0", mem_req); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ack_ignored();
      test_clkref();
      test_overflow();
      test_header();
      test_index();
      test_reset_req();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ioctl_rom_writer.md
IOCTL_ROM_WRITER -- requirements
Module: ioctl_rom_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning word-FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ROM_INDEX, default 8'h00, meaning ioctl_index value whose writes are queued.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ioctl_download, input, 1, download-active level.
REQ-006 SHALL have port ioctl_index, input, 8, menu index of the current file.
REQ-007 SHALL have port ioctl_wr, input, 1, one-cycle word-valid strobe.
REQ-008 SHALL have port ioctl_addr, input, 25, word address.
REQ-009 SHALL have port ioctl_dout, input, 16, data word: [15:8] is the even byte, [7:0] is the odd byte.
REQ-010 SHALL have port ioctl_clkref, output, 1, pacing level to the upstream loader.
REQ-011 SHALL have port mem_req, output, 1, memory write request.
REQ-012 SHALL have port mem_addr, output, 24, memory word address.
REQ-013 SHALL have port mem_din, output, 16, memory write data.
REQ-014 SHALL have port mem_ack, input, 1, one-cycle write-complete pulse.
REQ-015 SHALL have port rom_loaded, output, 1, one-cycle pulse when a download is fully committed.
REQ-016 SHALL have port rom_words, output, 25, count of words written in the last download.
REQ-017 SHALL have port cart_type, output, 8, header byte 0x147.
REQ-018 SHALL have port rom_size, output, 8, header byte 0x148.
REQ-019 SHALL have port ram_size, output, 8, header byte 0x149.
REQ-020 SHALL have port overflow, output, 1, sticky flag: a write arrived while the FIFO was full.

Function
REQ-021 SHALL push {ioctl_addr, ioctl_dout} into the FIFO on a cycle where ioctl_wr=1, ioctl_download=1, ioctl_index==ROM_INDEX, and the FIFO is not full; other writes are not queued.
REQ-022 SHALL drop a qualifying write that arrives while the FIFO is full, and set overflow.
REQ-023 SHALL drive ioctl_clkref high, registered, whenever FIFO occupancy <= FIFO_DEPTH-2, and low otherwise; the two-slot margin covers the one-cycle upstream edge-to-write latency.
REQ-024 SHALL implement the memory FSM with states IDLE, REQ, DRAIN.
REQ-025 IDLE SHALL go to REQ when the FIFO is non-empty, one cycle later, loading mem_addr=fifo_addr[23:0] and mem_din=fifo_data, and asserting mem_req.
REQ-026 In REQ, mem_req, mem_addr and mem_din SHALL be held stable until mem_ack=1.
REQ-027 On mem_ack in REQ, the FSM SHALL pop the FIFO, deassert mem_req in the next cycle, and return to IDLE (or to DRAIN if the download has ended).
REQ-028 mem_ack outside REQ SHALL be ignored.
REQ-029 A falling edge of ioctl_download SHALL arm the drain; when the FIFO is empty and the FSM is idle, the block SHALL pulse rom_loaded for one cycle and latch rom_words = highest accepted ioctl_addr + 1, or 0 if no word was accepted.
REQ-030 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-031 SHALL capture header bytes on push:
  - word 0xA3: [7:0] -> cart_type
  - word 0xA4: [15:8] -> rom_size, [7:0] -> ram_size
REQ-032 A rising edge of ioctl_download SHALL clear overflow, cart_type, rom_size, ram_size, and the max-address tracker; rom_words keeps its previous value until the next rom_loaded.
REQ-033 Bit 24 of the FIFO address SHALL be discarded at mem_addr; the address wraps modulo 2^24 words.

Reset
REQ-034 While reset_n=0, the block SHALL force these values: FSM=IDLE, FIFO empty, mem_req=0, mem_addr=0, mem_din=0, ioctl_clkref=0, rom_loaded=0, rom_words=0, cart_type=0, rom_size=0, ram_size=0, overflow=0.
REQ-035 On the first clock after reset release, ioctl_clkref SHALL go high.
REQ-036 Reset during REQ SHALL abandon the pending write without further handshake.

Structure
REQ-037 FSM state encodings and header word offsets (0xA3, 0xA4) SHALL reside in shared package gb_loader_pkg.
REQ-038 The FIFO SHALL be a separate sub-module, ioctl_word_fifo, with push, pop, full, empty and count ports; it is parameterised by width and depth.

Verification
REQ-039 Scenario: single write addr=0x000010, dout=0xBEEF, mem_ack 3 cycles after mem_req -> one request with mem_addr=0x000010, mem_din=0xBEEF, held stable until ack, then mem_req=0.
REQ-040 Scenario: mem_ack held off, 5 back-to-back writes gated only by ioctl_clkref -> clkref low at occupancy 3, no overflow, all 5 words written in order.
REQ-041 Scenario: 5 writes forced with clkref ignored and mem_ack withheld -> 5th word dropped, overflow=1, 4 words written after acks resume.
REQ-042 Scenario: download of 0x200 words with word 0xA3=0x0013 and 0xA4=0x0502 -> cart_type=0x13, rom_size=0x05, ram_size=0x02, rom_words=0x200, one rom_loaded pulse after the last ack.
REQ-043 Scenario: writes with ioctl_index=0x01 (ROM_INDEX=0) -> no mem_req, rom_loaded pulses at download end with rom_words=0.
REQ-044 Scenario: reset_n low while mem_req=1 -> mem_req=0 immediately, FIFO empty, ioctl_clkref=1 the first cycle after release.
